// File: rtl/bmc_soft_pipe.sv
// ---------------------------------------------------------------------------
// bmc_soft_pipe
//   Branch-metric unit for the Viterbi decoder front end. Takes N soft
//   symbols (Q bits each, offset binary) per trellis step. Produces the
//   branch metric for every one of the 2^N candidate code words. The
//   datapath is a 2-stage pipeline with valid/ready flow control, and it
//   carries frame-last and an in-frame symbol index alongside the data.
//
// Parameters
//   N      code symbols per trellis step (N >= 2)
//   Q      soft-decision bits per symbol (Q = 1 is hard decision)
//   CNT_W  width of the in-frame symbol index
//   MW     metric width, derived as Q + clog2(N)
//
// Ports
//   clk, rst_n          rising-edge clock; synchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_sym [N*Q]        symbol i at [i*Q +: Q]
//   in_last             last beat of the frame
//   in_erase [N]        per-symbol erasure mask (BMC_PUNCTURE_EN only)
//   out_valid/out_ready output handshake
//   out_bm [2^N*MW]     metric for code word j at [j*MW +: MW]
//   out_last, out_idx   frame-last and symbol index of the output beat
//
// Build option
//   BMC_PUNCTURE_EN     adds in_erase; an erased symbol contributes nothing
// ---------------------------------------------------------------------------
module bmc_soft_pipe #(
  parameter int unsigned N     = 2,
  parameter int unsigned Q     = 3,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned MW   = Q + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*Q-1:0]        in_sym,
  input  logic                  in_last,
`ifdef BMC_PUNCTURE_EN
  input  logic [N-1:0]          in_erase,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**N)*MW-1:0]  out_bm,
  output logic                  out_last,
  output logic [CNT_W-1:0]      out_idx
);

  localparam int unsigned NW = 2**N;
  localparam logic [Q-1:0] SMAX = '1;

  logic                   en;
  logic                   accept;
  logic [CNT_W-1:0]       idx_cnt;

  logic                   s1_valid;
  logic [N-1:0][Q-1:0]    s1_d0;
  logic [N-1:0][Q-1:0]    s1_d1;
  logic                   s1_last;
  logic [CNT_W-1:0]       s1_idx;
`ifdef BMC_PUNCTURE_EN
  logic [N-1:0]           s1_erase;
`endif

  logic [NW*MW-1:0]       bm_next;
  logic [MW-1:0]          acc;

  // Both stages advance together; bubbles are kept, never squeezed out.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && rst_n;
  assign accept   = in_valid && in_ready;

  // Bit i of code word j selects d1 (expected '1') or d0 (expected '0')
  // for symbol i. The worst case N*(2^Q-1) always fits in MW bits.
  always_comb begin
    bm_next = '0;
    acc     = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      acc = '0;
      for (int unsigned i = 0; i < N; i++) begin
`ifdef BMC_PUNCTURE_EN
        if (!s1_erase[i])
`endif
          acc = acc + ((((j >> i) & 1) != 0) ? MW'(s1_d1[i]) : MW'(s1_d0[i]));
      end
      bm_next[j*MW +: MW] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_cnt   <= '0;
      s1_valid  <= 1'b0;
      s1_d0     <= '0;
      s1_d1     <= '0;
      s1_last   <= 1'b0;
      s1_idx    <= '0;
`ifdef BMC_PUNCTURE_EN
      s1_erase  <= '0;
`endif
      out_valid <= 1'b0;
      out_bm    <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else begin
      // Frame end wins over increment; natural wrap at 2^CNT_W.
      if (accept) begin
        idx_cnt <= in_last ? '0 : idx_cnt + CNT_W'(1);
      end

      if (en) begin
        s1_valid <= accept;
        if (accept) begin
          for (int unsigned i = 0; i < N; i++) begin
            s1_d0[i] <= in_sym[i*Q +: Q];
            s1_d1[i] <= SMAX - in_sym[i*Q +: Q];
          end
          s1_last  <= in_last;
          s1_idx   <= idx_cnt;
`ifdef BMC_PUNCTURE_EN
          s1_erase <= in_erase;
`endif
        end

        out_valid <= s1_valid;
        // Payload only changes when a real beat moves in, so the outputs
        // also stay put across bubbles.
        if (s1_valid) begin
          out_bm   <= bm_next;
          out_last <= s1_last;
          out_idx  <= s1_idx;
        end
      end
    end
  end

endmodule
